// File: rtl/dm_load_align_pkg.sv
// Shared definitions for the load-alignment unit: size codes, FSM encoding
// and the word-boundary crossing test.
package dm_load_align_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT0 = 2'd1,
    ST_WAIT1 = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  // True when an access of 1<<size bytes at byte offset off spills past a word.
  function automatic logic crosses(input int unsigned off, input logic [1:0] size,
                                   input int unsigned wbytes);
    return (off + (32'd1 << size)) > wbytes;
  endfunction

endpackage

// File: rtl/dm_extract.sv
// Combinational extractor: shifts a two-word window down to the byte offset,
// keeps 8n bits and sign/zero-extends to DW.
module dm_extract
  import dm_load_align_pkg::*;
#(
  parameter int DW = 32,
  localparam int OW = $clog2(DW/8)
) (
  input  logic [2*DW-1:0] window,
  input  logic [OW-1:0]   off,
  input  logic [1:0]      size,
  input  logic            sgn,
  output logic [DW-1:0]   res
);

  logic [DW-1:0] sh;
  logic [6:0]    nbits;
  logic          fill;

  assign sh = DW'(window >> {off, 3'b000});

  always_comb begin
    nbits = 7'd8 << size;
    fill  = 1'b0;
    case (size)
      SZ_B:    fill = sgn & sh[7];
      SZ_H:    fill = sgn & sh[15];
      SZ_W:    fill = (DW > 32) ? (sgn & sh[31]) : 1'b0;
      default: fill = 1'b0;
    endcase
  end

  // Bits below the access width pass through; the rest take the fill bit.
  for (genvar i = 0; i < DW; i++) begin : g_bit
    assign res[i] = (7'(i) < nbits) ? sh[i] : fill;
  end

endmodule

// File: rtl/dm_load_align.sv
// Load-alignment unit: issues one or two word reads to a variable-latency
// memory, merges and extends the result, and returns it over valid/ready.
module dm_load_align
  import dm_load_align_pkg::*;
#(
  parameter int DW    = 32,
  parameter int AW    = 32,
  parameter int SPLIT = 1,
  parameter int TW    = 5
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [AW-1:0] req_addr,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [TW-1:0] req_tag,
  output logic          mem_rd_en,
  output logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_rvalid,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic [TW-1:0] rsp_tag,
  output logic          rsp_err
);

  localparam int WB = DW/8;
  localparam int OW = $clog2(WB);

  typedef struct packed {
    logic [OW-1:0] off;
    logic [1:0]    size;
    logic          sgn;
    logic [TW-1:0] tag;
  } req_t;

  state_t          state, state_nx;
  req_t            r;
  logic [DW-1:0]   lo, ext;
  logic [2*DW-1:0] window;
  logic            cross_in, cross_r, bad;

  assign cross_in = crosses(32'(req_addr[OW-1:0]), req_size, WB);
  assign cross_r  = crosses(32'(r.off), r.size, WB);
  assign bad      = (req_size == SZ_D && DW == 32) || (cross_in && SPLIT == 0);

  // Second read arrives as the upper word; a single read only fills the low half.
  assign window = (state == ST_WAIT1) ? {mem_rdata, lo} : {{DW{1'b0}}, mem_rdata};

  dm_extract #(.DW(DW)) u_ext (
    .window (window),
    .off    (r.off),
    .size   (r.size),
    .sgn    (r.sgn),
    .res    (ext)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (req_valid)  state_nx = bad ? ST_RESP : ST_WAIT0;
      ST_WAIT0: if (mem_rvalid) state_nx = cross_r ? ST_WAIT1 : ST_RESP;
      ST_WAIT1: if (mem_rvalid) state_nx = ST_RESP;
      ST_RESP:  if (rsp_ready)  state_nx = ST_IDLE;
      default:                  state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == ST_IDLE);
    rsp_valid = (state == ST_RESP);
  end

  assign rsp_tag = r.tag;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r         <= '0;
      lo        <= '0;
      mem_rd_en <= 1'b0;
      mem_addr  <= '0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      mem_rd_en <= 1'b0;
      case (state)
        ST_IDLE: if (req_valid) begin
          r <= '{off: req_addr[OW-1:0], size: req_size, sgn: req_signed, tag: req_tag};
          if (bad) begin
            rsp_err  <= 1'b1;
            rsp_data <= '0;
          end else begin
            rsp_err   <= 1'b0;
            mem_rd_en <= 1'b1;
            mem_addr  <= {req_addr[AW-1:OW], {OW{1'b0}}};
          end
        end
        ST_WAIT0: if (mem_rvalid) begin
          lo <= mem_rdata;
          if (cross_r) begin
            mem_rd_en <= 1'b1;
            mem_addr  <= mem_addr + AW'(WB);
          end else begin
            rsp_data <= ext;
          end
        end
        ST_WAIT1: if (mem_rvalid) rsp_data <= ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_load_align.sv
// Scoreboard bench for dm_load_align (DW=32): byte-level reference model,
// latency-modelled memory, directed corner cases and randomized loads.
module tb_dm_load_align;
  import dm_load_align_pkg::*;

  logic        clk = 1'b0, reset_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 0, req_ready, req_signed = 0;
  logic [31:0] req_addr = 0;
  logic [1:0]  req_size = 0;
  logic [4:0]  req_tag = 0;
  logic        mem_rd_en, mem_rvalid = 0, rsp_valid, rsp_ready = 0, rsp_err;
  logic [31:0] mem_addr, mem_rdata = 0, rsp_data;
  logic [4:0]  rsp_tag;

  logic        s_req_valid = 0, s_req_ready, s_req_signed = 0;
  logic [31:0] s_req_addr = 0;
  logic [1:0]  s_req_size = 0;
  logic [4:0]  s_req_tag = 0;
  logic        s_mem_rd_en, s_mem_rvalid = 0, s_rsp_valid, s_rsp_err;
  logic [31:0] s_mem_addr, s_mem_rdata = 0, s_rsp_data;
  logic [4:0]  s_rsp_tag;
  int          s_rds = 0;

  dm_load_align #(.DW(32), .AW(32), .SPLIT(1), .TW(5)) u_dut (
    .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_size(req_size), .req_signed(req_signed), .req_tag(req_tag),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
    .rsp_err(rsp_err));

  dm_load_align #(.DW(32), .AW(32), .SPLIT(0), .TW(5)) u_nosplit (
    .clk(clk), .reset_n(reset_n), .req_valid(s_req_valid), .req_ready(s_req_ready),
    .req_addr(s_req_addr), .req_size(s_req_size), .req_signed(s_req_signed), .req_tag(s_req_tag),
    .mem_rd_en(s_mem_rd_en), .mem_addr(s_mem_addr), .mem_rdata(s_mem_rdata),
    .mem_rvalid(s_mem_rvalid), .rsp_valid(s_rsp_valid), .rsp_ready(1'b1), .rsp_data(s_rsp_data),
    .rsp_tag(s_rsp_tag), .rsp_err(s_rsp_err));

  int  nvec = 0, nerr = 0, cyc = 0, lat = 2;
  bit  hold = 0, mon_seen = 0;
  logic [7:0] mb [64];

  typedef struct {
    logic [31:0] d;
    logic [4:0]  tag;
    logic        err;
    int          exp_cyc;
  } exp_t;
  exp_t        q[$];
  logic [31:0] rdq[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm, input string why);
    nvec++;
    nerr++;
    $display("FAIL %s: %s", nm, why);
  endtask

  function automatic logic [31:0] wrd(input logic [31:0] a);
    logic [31:0] w;
    for (int k = 0; k < 4; k++) w[8*k +: 8] = mb[6'(a + 32'(k))];
    return w;
  endfunction

  task automatic setw(input logic [31:0] a, input logic [31:0] v);
    for (int k = 0; k < 4; k++) mb[6'(a + 32'(k))] = v[8*k +: 8];
  endtask

  // Reference: gather n bytes little-endian from byte memory, then extend.
  function automatic exp_t model(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                                 input logic [4:0] tg, input int acc);
    exp_t        e;
    int          n;
    logic [31:0] v;
    n = 1 << sz;
    v = '0;
    e.tag = tg;
    if (sz == 2'd3) begin
      e.err = 1'b1; e.d = '0; e.exp_cyc = acc + 1;
    end else begin
      for (int k = 0; k < n; k++) v[8*k +: 8] = mb[6'(a + 32'(k))];
      if (sg && n < 4 && v[8*n-1]) for (int b = 8*n; b < 32; b++) v[b] = 1'b1;
      e.err = 1'b0;
      e.d   = v;
      e.exp_cyc = acc + ((int'(a[1:0]) + n > 4) ? 2*lat + 3 : lat + 2);
    end
    return e;
  endfunction

  // Called one step after a rising edge; returns one step after the accepting edge.
  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                       input logic [4:0] tg);
    int t = 0;
    while (!req_ready && t < 200) begin @(posedge clk); #1; t++; end
    if (!req_ready) begin fail_now("req_ready_timeout", "got req_ready=0 expected 1"); return; end
    req_valid = 1; req_addr = a; req_size = sz; req_signed = sg; req_tag = tg;
    q.push_back(model(a, sz, sg, tg, cyc));
    if (sz != 2'd3) begin
      rdq.push_back({a[31:2], 2'b00});
      if (int'(a[1:0]) + (1 << sz) > 4) rdq.push_back({a[31:2], 2'b00} + 32'd4);
    end
    @(posedge clk); #1;
    req_valid = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (!(q.size() == 0 && rdq.size() == 0 && req_ready) && t < 500) begin
      @(posedge clk); #1; t++;
    end
    if (t >= 500) fail_now("drain_timeout", $sformatf("got %0d pending expected 0", q.size()));
  endtask

  // Memory model: latency lat from read strobe to rvalid, data from byte memory.
  initial begin
    logic [31:0] ma;
    forever begin
      @(posedge clk); #1;
      mem_rvalid = 0;
      if (mem_rd_en) begin
        ma = mem_addr;
        if (rdq.size() == 0) fail_now("unexpected_read", $sformatf("got read at %h expected none", ma));
        else chk("mem_addr", ma, rdq.pop_front());
        repeat (lat) @(posedge clk);
        #1;
        mem_rvalid = 1;
        mem_rdata  = wrd(ma);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      rsp_ready = hold ? 1'b0 : ($urandom_range(3) != 0);
    end
  end

  // Monitor: latency on first rsp_valid cycle, contents on handshake.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) mon_seen = 0;
      else begin
        if (rsp_valid && !mon_seen) begin
          mon_seen = 1;
          if (q.size() == 0) fail_now("unexpected_rsp", $sformatf("got data %h expected none", rsp_data));
          else chk("rsp_latency", 32'(cyc), 32'(q[0].exp_cyc));
        end
        if (rsp_valid && rsp_ready) begin
          mon_seen = 0;
          if (q.size() != 0) begin
            e = q.pop_front();
            chk("rsp_data", rsp_data, e.d);
            chk("rsp_tag", 32'(rsp_tag), 32'(e.tag));
            chk("rsp_err", 32'(rsp_err), 32'(e.err));
          end
        end
      end
    end
  end

  // SPLIT=0 instance: single-cycle memory, checked by direct comparisons.
  always @(posedge clk) begin
    s_mem_rvalid <= s_mem_rd_en;
    s_mem_rdata  <= wrd(s_mem_addr);
    if (s_mem_rd_en) s_rds <= s_rds + 1;
  end

  task automatic s_issue(input logic [31:0] a, input logic [1:0] sz, input logic sg,
                         input logic [4:0] tg, input logic [31:0] ed, input logic ee,
                         input int elat, input int erd);
    int t = 0, acc, r0;
    while (!s_req_ready && t < 50) begin @(posedge clk); #1; t++; end
    s_req_valid = 1; s_req_addr = a; s_req_size = sz; s_req_signed = sg; s_req_tag = tg;
    acc = cyc; r0 = s_rds;
    @(posedge clk); #1;
    s_req_valid = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!s_rsp_valid && t < 50);
    if (!s_rsp_valid) begin fail_now("ns_rsp_timeout", "got rsp_valid=0 expected 1"); return; end
    chk("ns_latency", 32'(cyc - acc), 32'(elat));
    chk("ns_data", s_rsp_data, ed);
    chk("ns_err", 32'(s_rsp_err), 32'(ee));
    chk("ns_tag", 32'(s_rsp_tag), 32'(tg));
    @(posedge clk); #1;
    chk("ns_reads", 32'(s_rds - r0), 32'(erd));
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({pfx, "_mem_rd_en"}, 32'(mem_rd_en), 32'd0);
    chk({pfx, "_mem_addr"},  mem_addr, 32'd0);
    chk({pfx, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    chk({pfx, "_rsp_data"},  rsp_data, 32'd0);
    chk({pfx, "_rsp_tag"},   32'(rsp_tag), 32'd0);
    chk({pfx, "_rsp_err"},   32'(rsp_err), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");
    reset_n = 1;
    @(posedge clk); #1;

    lat = 2;
    setw(32'h1000, 32'h80ABCDEF); issue(32'h1003, SZ_B, 1'b1, 5'd1); drain();
    setw(32'h1000, 32'h80011234); issue(32'h1002, SZ_H, 1'b0, 5'd2); drain();
    setw(32'h1004, 32'h44332211); setw(32'h1008, 32'h88776655);
    issue(32'h1006, SZ_W, 1'b0, 5'd3); drain();
    setw(32'h1000, 32'h80ABCDEF); setw(32'h1004, 32'h443322F1);
    issue(32'h1003, SZ_H, 1'b1, 5'd4); drain();
    issue(32'h1000, SZ_D, 1'b0, 5'd5); drain();

    // Backpressure: response must hold while rsp_ready stays low.
    hold = 1;
    @(posedge clk); #1;
    setw(32'h1000, 32'h80011234); issue(32'h1002, SZ_H, 1'b0, 5'd6);
    t = 0;
    do begin @(negedge clk); t++; end while (!rsp_valid && t < 50);
    repeat (5) begin
      @(negedge clk);
      chk("hold_valid", 32'(rsp_valid), 32'd1);
      chk("hold_data", rsp_data, 32'h00008001);
      chk("hold_tag", 32'(rsp_tag), 32'd6);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    @(posedge clk); #1;
    hold = 0;
    drain();

    // Reset while waiting on the first read; its late rvalid must be ignored.
    lat = 4;
    setw(32'h1000, 32'h12345678); issue(32'h1000, SZ_W, 1'b0, 5'd7);
    @(posedge clk); #1;
    reset_n = 0;
    q.delete(); rdq.delete();
    #1;
    chk_reset("midreset");
    @(posedge clk); #1;
    reset_n = 1;
    repeat (6) begin @(posedge clk); #1; end
    chk("post_reset_ready", 32'(req_ready), 32'd1);
    chk("post_reset_valid", 32'(rsp_valid), 32'd0);
    lat = 2;
    setw(32'h0, 32'h000000FF); issue(32'h0, SZ_B, 1'b0, 5'd8); drain();

    for (int l = 1; l <= 3; l++) begin
      lat = l;
      for (int i = 0; i < 64; i++) mb[i] = 8'($urandom);
      for (int n = 0; n < 60; n++) begin
        logic [1:0] sz;
        repeat ($urandom_range(2)) begin @(posedge clk); #1; end
        sz = ($urandom_range(7) == 0) ? SZ_D : 2'($urandom_range(2));
        issue($urandom, sz, 1'($urandom), 5'($urandom));
      end
      drain();
    end

    setw(32'h1000, 32'h80ABCDEF);
    s_issue(32'h1002, SZ_W, 1'b0, 5'd9,  32'h0,        1'b1, 1, 0);
    s_issue(32'h1000, SZ_D, 1'b0, 5'd10, 32'h0,        1'b1, 1, 0);
    s_issue(32'h1001, SZ_B, 1'b1, 5'd11, 32'hFFFFFFCD, 1'b0, 3, 1);
    s_issue(32'h1001, SZ_H, 1'b0, 5'd12, 32'h0000ABCD, 1'b0, 3, 1);
    s_issue(32'h1003, SZ_H, 1'b0, 5'd13, 32'h0,        1'b1, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
